// File: rtl/biss_pkg.sv
// Shared types and constants for the BiSS-C slave emulator and its CRC6 engine.
package biss_pkg;

   localparam int CRC_W     = 6;
   localparam logic [CRC_W-1:0] CRC6_POLY = 6'h03;
   localparam int NUM_FLAGS = 2;

   typedef enum logic [6:0] {
      S_IDLE  = 7'b000_0001,
      S_ARM   = 7'b000_0010,
      S_ACK   = 7'b000_0100,
      S_START = 7'b000_1000,
      S_DATA  = 7'b001_0000,
      S_CRC   = 7'b010_0000,
      S_TOUT  = 7'b100_0000
   } state_e;

   // Counter width that never collapses to zero bits for tiny parameters.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/biss_crc6_serial.sv
// Bit-serial CRC6 (x^6+x+1), MSB-first, zero init; clr has priority over en.
module biss_crc6_serial
   import biss_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] crc_q, crc_d;
   logic             fb;

   always_comb begin
      fb    = crc_q[CRC_W-1] ^ bit_in;
      crc_d = crc_q;
      if (clr)
         crc_d = '0;
      else if (en)
         crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & CRC6_POLY);
   end

   always_ff @(posedge clk) begin
      if (reset)
         crc_q <= '0;
      else
         crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/biss_slave_emu.sv
// BiSS-C slave emulator: answers each MA burst with Ack, Start, CDS, position,
// nE, nW, inverted CRC6 and a timeout phase on SLO.
module biss_slave_emu
   import biss_pkg::*;
#(
   parameter int POS_W       = 32,
   parameter int ACK_LEN     = 1,
   parameter int TIMEOUT_CYC = 1000,
   parameter int LINE_TO_CYC = 4000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enc_clk_in,
   output logic             enc_data_out,
   input  logic [POS_W-1:0] position_in,
   input  logic             err_in,
   input  logic             warn_in,
   output logic             busy,
   output logic             frame_done,
   output logic             frame_abort
);

   localparam int SH_W  = POS_W + NUM_FLAGS;
   localparam int BIT_W = clog2_min1(SH_W);
   localparam int ACK_W = clog2_min1(ACK_LEN + 1);
   localparam int CC_W  = clog2_min1(CRC_W + 1);
   localparam int TMR_W = clog2_min1(max_int(TIMEOUT_CYC, LINE_TO_CYC));

   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SH_W - 1);
   localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_LEN);
   localparam logic [CC_W-1:0]  CRC_LAST  = CC_W'(CRC_W);
   localparam logic [TMR_W-1:0] TOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] LINE_LAST = TMR_W'(LINE_TO_CYC - 1);

   logic             ma_s1_q, ma_s2_q, ma_s3_q;
   logic             ma_fall, ma_rise;
   state_e           state_q;
   logic [SH_W-1:0]  shadow_q;
   logic [ACK_W-1:0] ack_cnt_q;
   logic [BIT_W-1:0] bit_cnt_q;
   logic [CC_W-1:0]  crc_cnt_q;
   logic [TMR_W-1:0] tmr_q, tmr_inc;
   logic             slo_q, busy_q, done_q, abort_q;
   logic             line_active, line_expire;
   logic             crc_clr, crc_en;
   logic [CRC_W-1:0] crc_val, crc_inv_sh;
   logic             crc_tx_bit;

   // Synchronisers reset high so a reset never fakes an MA falling edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         ma_s1_q <= 1'b1;
         ma_s2_q <= 1'b1;
         ma_s3_q <= 1'b1;
      end else begin
         ma_s1_q <= enc_clk_in;
         ma_s2_q <= ma_s1_q;
         ma_s3_q <= ma_s2_q;
      end
   end

   assign ma_fall = ma_s3_q & ~ma_s2_q;
   assign ma_rise = ~ma_s3_q & ma_s2_q;

   assign tmr_inc     = (&tmr_q) ? tmr_q : tmr_q + TMR_W'(1);
   assign line_active = (state_q == S_ARM) || (state_q == S_ACK) || (state_q == S_START) ||
                        (state_q == S_DATA) || (state_q == S_CRC);
   assign line_expire = line_active && !ma_fall && (tmr_q == LINE_LAST);

   assign crc_clr    = (state_q == S_IDLE) && ma_fall;
   assign crc_en     = (state_q == S_DATA) && ma_rise;
   assign crc_inv_sh = (~crc_val) << crc_cnt_q;
   assign crc_tx_bit = crc_inv_sh[CRC_W-1];

   biss_crc6_serial u_crc (
      .clk    (clk),
      .reset  (reset),
      .clr    (crc_clr),
      .en     (crc_en),
      .bit_in (shadow_q[SH_W-1]),
      .crc    (crc_val)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shadow_q  <= '0;
         ack_cnt_q <= '0;
         bit_cnt_q <= '0;
         crc_cnt_q <= '0;
         tmr_q     <= '0;
         slo_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         if (line_active) begin
            if (ma_fall)
               tmr_q <= '0;
            else if (ma_s2_q)
               tmr_q <= tmr_inc;
         end
         unique case (state_q)
            S_IDLE: begin
               slo_q <= 1'b1;
               if (ma_fall) begin
                  shadow_q <= {position_in, ~err_in, ~warn_in};
                  busy_q   <= 1'b1;
                  tmr_q    <= '0;
                  state_q  <= S_ARM;
               end
            end
            S_ARM: if (ma_rise) begin
               slo_q     <= 1'b0;
               ack_cnt_q <= ACK_W'(1);
               state_q   <= S_ACK;
            end
            S_ACK: if (ma_rise) begin
               if (ack_cnt_q == ACK_LAST) begin
                  slo_q   <= 1'b1;
                  state_q <= S_START;
               end else begin
                  ack_cnt_q <= ack_cnt_q + ACK_W'(1);
               end
            end
            S_START: if (ma_rise) begin
               slo_q     <= 1'b0;
               bit_cnt_q <= '0;
               state_q   <= S_DATA;
            end
            S_DATA: if (ma_rise) begin
               slo_q     <= shadow_q[SH_W-1];
               shadow_q  <= {shadow_q[SH_W-2:0], 1'b0};
               bit_cnt_q <= bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == BIT_LAST) begin
                  crc_cnt_q <= '0;
                  state_q   <= S_CRC;
               end
            end
            S_CRC: if (ma_rise) begin
               if (crc_cnt_q == CRC_LAST) begin
                  slo_q   <= 1'b0;
                  tmr_q   <= '0;
                  state_q <= S_TOUT;
               end else begin
                  slo_q     <= crc_tx_bit;
                  crc_cnt_q <= crc_cnt_q + CC_W'(1);
               end
            end
            S_TOUT: begin
               slo_q <= 1'b0;
               // A fresh MA burst restarts the timeout instead of starting a frame.
               if (ma_fall) begin
                  tmr_q <= '0;
               end else if (tmr_q == TOUT_LAST) begin
                  slo_q   <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (ma_s2_q) begin
                  tmr_q <= tmr_inc;
               end
            end
            default: begin
               slo_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
         if (line_expire) begin
            slo_q   <= 1'b1;
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
         end
      end
   end

   assign enc_data_out = slo_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign frame_abort  = abort_q;

endmodule

// File: tb/tb_biss_slave_emu.sv
// Directed bench for biss_slave_emu: table of frames plus abort/reset/latch/ACK_LEN=3 sequences.
module tb_biss_slave_emu;
   import biss_pkg::*;

   localparam int TO  = 20;
   localparam int LTO = 60;
   localparam int HP  = 6;

   typedef struct {
      logic [31:0] pos;
      logic        err;
      logic        warn;
      logic        ne;
      logic        nw;
      logic        use_model;
      logic [5:0]  crc_tx;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, ma, use3;
   logic [31:0] pos_in;
   logic        err_in, warn_in;
   logic        slo1, busy1, done1, abort1;
   logic        slo3, busy3, done3, abort3;
   logic        slo, busy;
   wire         ma1 = use3 ? 1'b1 : ma;
   wire         ma3 = use3 ? ma : 1'b1;

   int total = 0, bad = 0, cyc = 0;
   int done_cnt = 0, abort_cnt = 0, done_cyc = 0, abort_cyc = 0, rise_cyc = 0;
   logic samp [64];
   vec_t tv [5];

   always #5 clk = ~clk;

   biss_slave_emu #(.POS_W(32), .ACK_LEN(1), .TIMEOUT_CYC(TO), .LINE_TO_CYC(LTO)) dut (
      .clk(clk), .reset(reset), .enc_clk_in(ma1), .enc_data_out(slo1),
      .position_in(pos_in), .err_in(err_in), .warn_in(warn_in),
      .busy(busy1), .frame_done(done1), .frame_abort(abort1));

   biss_slave_emu #(.POS_W(32), .ACK_LEN(3), .TIMEOUT_CYC(TO), .LINE_TO_CYC(LTO)) dut3 (
      .clk(clk), .reset(reset), .enc_clk_in(ma3), .enc_data_out(slo3),
      .position_in(pos_in), .err_in(err_in), .warn_in(warn_in),
      .busy(busy3), .frame_done(done3), .frame_abort(abort3));

   assign slo  = use3 ? slo3 : slo1;
   assign busy = use3 ? busy3 : busy1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (done1 | done3) begin done_cnt++; done_cyc = cyc; end
      if (abort1 | abort3) begin abort_cnt++; abort_cyc = cyc; end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [5:0] crc6(input logic [33:0] d);
      logic [5:0] c;
      logic       fb;
      c = 6'h0;
      for (int i = 33; i >= 0; i--) begin
         fb = c[5] ^ d[i];
         c  = {c[4:0], fb} ^ {4'b0, fb, 1'b0};
      end
      return c;
   endfunction

   task automatic burst(input int nrise, input int chg_k, input logic [31:0] chg_pos);
      @(negedge clk);
      ma = 1'b0;
      repeat (HP) @(negedge clk);
      for (int k = 0; k < nrise; k++) begin
         ma = 1'b1;
         rise_cyc = cyc;
         repeat (HP) @(negedge clk);
         samp[k] = slo;
         if (k == 0) chk("busy_mid", busy, 1);
         if (k == chg_k) pos_in = chg_pos;
         if (k < nrise - 1) begin
            ma = 1'b0;
            repeat (HP) @(negedge clk);
         end
      end
   endtask

   task automatic check_frame(input int a, input logic [31:0] p, input logic ne, input logic nw,
                              input logic [5:0] crc_tx, input string tag);
      logic        ackv;
      logic [31:0] pv;
      logic [5:0]  cv;
      ackv = 1'b0;
      for (int i = 0; i < a; i++) ackv = ackv | samp[i];
      chk($sformatf("%s_ack_low", tag), ackv, 0);
      chk($sformatf("%s_start", tag), samp[a], 1);
      chk($sformatf("%s_cds", tag), samp[a+1], 0);
      pv = '0;
      for (int i = 0; i < 32; i++) pv = {pv[30:0], samp[a+2+i]};
      chk($sformatf("%s_pos", tag), pv, p);
      chk($sformatf("%s_nE", tag), samp[a+34], ne);
      chk($sformatf("%s_nW", tag), samp[a+35], nw);
      cv = '0;
      for (int i = 0; i < 6; i++) cv = {cv[4:0], samp[a+36+i]};
      chk($sformatf("%s_crc", tag), cv, crc_tx);
      chk($sformatf("%s_tout_low", tag), samp[a+42], 0);
   endtask

   task automatic finish_frame(input int d0, input int a0, input string tag);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 300) begin @(negedge clk); n++; end
      chk($sformatf("%s_done_lat", tag), done_cyc - rise_cyc, TO + 3);
      repeat (3) @(negedge clk);
      chk($sformatf("%s_done_once", tag), done_cnt - d0, 1);
      chk($sformatf("%s_no_abort", tag), abort_cnt - a0, 0);
      chk($sformatf("%s_slo_idle", tag), slo, 1);
      chk($sformatf("%s_busy_idle", tag), busy, 0);
   endtask

   task automatic full_frame(input int a, input int chg_k, input logic [31:0] chg_pos,
                             input logic [31:0] p, input logic ne, input logic nw,
                             input logic [5:0] crc_tx, input string tag);
      int d0, a0;
      d0 = done_cnt;
      a0 = abort_cnt;
      burst(a + 43, chg_k, chg_pos);
      check_frame(a, p, ne, nw, crc_tx, tag);
      finish_frame(d0, a0, tag);
   endtask

   initial begin
      int d0, a0, n;
      logic [5:0] ce;
      tv[0] = '{32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h00};
      tv[1] = '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3F};
      tv[2] = '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h3C};
      tv[3] = '{32'hA5A50F0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00};
      tv[4] = '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h00};

      reset = 1'b1; ma = 1'b1; use3 = 1'b0;
      pos_in = '0; err_in = 1'b0; warn_in = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_slo", slo1, 1);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_abort", abort1, 0);
      chk("rst_slo3", slo3, 1);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_slo", slo1, 1);

      for (int i = 0; i < 5; i++) begin
         pos_in  = tv[i].pos;
         err_in  = tv[i].err;
         warn_in = tv[i].warn;
         ce = tv[i].use_model ? ~crc6({tv[i].pos, tv[i].ne, tv[i].nw}) : tv[i].crc_tx;
         full_frame(1, -1, '0, tv[i].pos, tv[i].ne, tv[i].nw, ce, $sformatf("vec%0d", i));
         repeat (5) @(negedge clk);
      end

      // Position changes after the latch must not leak into the frame.
      pos_in = 32'h12345678; err_in = 1'b0; warn_in = 1'b0;
      full_frame(1, 1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b1,
                 ~crc6({32'h12345678, 2'b11}), "latch");
      repeat (5) @(negedge clk);

      // MA parks high after 10 data bits: line timeout.
      pos_in = 32'h12345678;
      d0 = done_cnt; a0 = abort_cnt;
      burst(13, -1, '0);
      n = 0;
      while (abort_cnt == a0 && n < LTO + 50) begin @(negedge clk); n++; end
      chk("abort_lat", abort_cyc - rise_cyc, LTO + 2);
      repeat (2) @(negedge clk);
      chk("abort_once", abort_cnt - a0, 1);
      chk("abort_slo", slo1, 1);
      chk("abort_busy", busy1, 0);
      chk("abort_no_done", done_cnt - d0, 0);
      full_frame(1, -1, '0, 32'h12345678, 1'b1, 1'b1, ~crc6({32'h12345678, 2'b11}), "post_abort");
      repeat (5) @(negedge clk);

      // One-cycle reset in the middle of the data field.
      pos_in = 32'hA5A50F0F; err_in = 1'b0; warn_in = 1'b1;
      d0 = done_cnt; a0 = abort_cnt;
      burst(18, -1, '0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_slo", slo1, 1);
      chk("mrst_busy", busy1, 0);
      chk("mrst_state", dut.state_q, S_IDLE);
      repeat (LTO + 20) @(negedge clk);
      chk("mrst_no_done", done_cnt - d0, 0);
      chk("mrst_no_abort", abort_cnt - a0, 0);
      full_frame(1, -1, '0, 32'hA5A50F0F, 1'b1, 1'b0, ~crc6({32'hA5A50F0F, 2'b10}), "post_rst");
      repeat (5) @(negedge clk);

      // Three-rise Ack on the second instance.
      use3 = 1'b1;
      pos_in = 32'h12345678; err_in = 1'b1; warn_in = 1'b0;
      repeat (5) @(negedge clk);
      full_frame(3, -1, '0, 32'h12345678, 1'b0, 1'b1, ~crc6({32'h12345678, 2'b01}), "ack3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/biss_slave_emu.md
Name: biss_slave_emu

Overview:
- BiSS-C slave (encoder emulator) for the BiSS position master already in the design.
- Samples the master clock (MA) and returns one frame per MA burst on SLO: Ack, Start, CDS, position, nE, nW, inverted CRC6, then timeout.
- Used for loopback and HIL testing of the master, and as a position source toward external BiSS masters.

Parameters:
POS_W, 32, position field width in bits
ACK_LEN, 1, number of MA rising edges during which SLO is held low for Ack
TIMEOUT_CYC, 1000, clk cycles of MA-high after the last bit before SLO returns high
LINE_TO_CYC, 4000, clk cycles of MA-high mid-frame that abort the frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enc_clk_in  in  1  MA from master; asynchronous, idle high
enc_data_out  out  1  SLO to master; idle high
position_in  in  POS_W  live position value
err_in  in  1  error condition, active-high; sent inverted as nE
warn_in  in  1  warning condition, active-high; sent inverted as nW
busy  out  1  high from frame latch until return to IDLE
frame_done  out  1  one-cycle pulse when timeout completes normally
frame_abort  out  1  one-cycle pulse on line-timeout abort

Behaviour:
- Interface: one clock `clk`. `reset` is synchronous, active-high. All state changes on posedge clk.
- Reset values: enc_data_out=1, busy=0, frame_done=0, frame_abort=0, state=IDLE, all counters=0, CRC=0.
- Reset asserted mid-frame: the same values are applied on the next posedge, regardless of state.
- MA input path: 2-flop synchroniser, then a third flop for edge detect.
  - ma_fall and ma_rise are single-cycle strobes, 3 clk cycles after the pin edge.
- Each state and its behaviour:
  - IDLE: SLO=1. On ma_fall:
    - latch shadow = {position_in, ~err_in, ~warn_in} (POS_W+2 bits);
    - clear CRC, set busy, go to ARM.
  - ARM: on ma_rise, SLO=0, ack_cnt=1, go to ACK.
  - ACK: on each ma_rise:
    - if ack_cnt==ACK_LEN, SLO=1 (Start bit) and go to START;
    - otherwise ack_cnt++ with SLO held at 0.
  - START: on ma_rise, SLO=0 (CDS bit), bit_cnt=0, go to DATA.
  - DATA: on each ma_rise, SLO = shadow MSB, shadow shifts left, CRC updates with that bit, bit_cnt++.
    - The rise that drives bit index POS_W+1 (the last bit) moves to CRC with crc_cnt=0.
  - CRC: on each ma_rise, SLO = ~crc[5-crc_cnt], crc_cnt++.
    - After bit 0 has been driven, the next ma_rise drives SLO=0 and moves to TOUT.
  - TOUT: SLO=0.
    - The timer counts clk cycles while MA is high and clears on any ma_fall; an MA burst from the master is ignored.
    - When timer == TIMEOUT_CYC-1: SLO=1, frame_done pulses, busy=0, go to IDLE.
- Bit timing: SLO changes only in the cycle following an ma_rise strobe. The master samples on the following MA edge.
- CRC6:
  - Polynomial x^6+x+1 (0x43), initial value 0, MSB-first over the POS_W+2 data bits.
  - Update rule: fb = crc[5]^bit; crc = {crc[4:0],fb} ^ {4'b0,fb,1'b0}.
  - Transmitted inverted, MSB first.
- Line timeout, in ARM/ACK/START/DATA/CRC only:
  - A counter increments while MA is high and clears on ma_fall.
  - At LINE_TO_CYC-1: SLO=1, frame_abort pulses, busy=0, go to IDLE. No frame_done.
- Simultaneous events: reset beats everything.
  - ma_fall in TOUT restarts the timeout timer; the timer cannot expire in that same cycle.
  - position_in, err_in and warn_in changes after the latch do not affect the frame in flight.
- Widths:
  - bit_cnt is $clog2(POS_W+2) bits.
  - Timer counters are $clog2(max(TIMEOUT_CYC, LINE_TO_CYC)) bits and saturate; they never wrap.

Decomposition:
- Package biss_pkg holds:
  - one-hot state encoding (IDLE, ARM, ACK, START, DATA, CRC, TOUT);
  - CRC6_POLY = 6'h03 (low taps);
  - CRC_W = 6;
  - NUM_FLAGS = 2.
- Sub-module biss_crc6_serial: inputs clk, reset, clr, en, bit_in; output crc[5:0]. Shared later with a CRC checker for the master.

Test Plan:
- Basic frame: position_in=32'h12345678, err_in=0, warn_in=0, MA at 1 MHz from the master or a BFM. The captured 40-bit payload must be 0x12345678, nE=1, nW=1, and CRC must equal the golden model's ~CRC6. SLO must read low before the Start bit, and Start=1, CDS=0.
- Flags: err_in=1, warn_in=1, position=0. Expect nE=0, nW=0 and CRC matching the golden model. frame_done pulses exactly once, TIMEOUT_CYC cycles after the last MA rise.
- Latch isolation: change position_in to 32'hFFFFFFFF two MA periods after the first ma_fall. The frame still carries the value latched at the first ma_fall.
- Abort: stop MA high after 10 data bits for LINE_TO_CYC cycles. frame_abort pulses, SLO=1, busy=0. The next full frame is correct.
- Reset mid-DATA: assert reset for 1 cycle at bit 15. Next cycle SLO=1, busy=0, state IDLE, no done or abort pulse. The following frame is correct.
- ACK_LEN=3: SLO stays low for 3 MA rises before Start. Loopback against the BiSS master with 32-bit position plus 8 status/CRC bits reports matching position and flags.
